// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   NUM_ROWS / NUM_COLS / NUM_KEYS : matrix geometry
//   scan_state_e                   : one state per driven column
//   col_drive()                    : active-low column pattern for a scan state
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } scan_state_e;

    function automatic logic [NUM_COLS-1:0] col_drive(scan_state_e s);
        return ~(NUM_COLS'(1) << s);
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix and key-event signal bundle.
//   row       : row lines from the matrix, active-low, pulled up
//   col       : column drive, exactly one bit low
//   key_state : debounced pressed level per key (1 = pressed)
//   key_pulse : one-cycle press strobe per key
// master = scanner side, slave = matrix / consumer side.
interface keypad_scan_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row;
    logic [NUM_COLS-1:0] col;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_KEYS-1:0] key_pulse;

    modport master (input row, output col, output key_state, output key_pulse);
    modport slave  (output row, input col, input key_state, input key_pulse);

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to all ones, i.e. the idle (released) level of the pulled-up rows.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous row lines
//   q_o   : synchronized row lines
module keypad_sync
    import keypad_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] d_i,
    output logic [NUM_ROWS-1:0] q_o
);

    logic [NUM_ROWS-1:0] ff1_q;
    logic [NUM_ROWS-1:0] ff2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= '1;
            ff2_q <= '1;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad column scanner with full-snapshot debounce.
// Each column is driven low for SCAN_DIV cycles; the synchronized rows are
// sampled on the last cycle of the slot. A 16-bit snapshot completes on the
// COL3 slot end and must repeat for DEBOUNCE_SCANS further scans before it is
// loaded into key_state. key_pulse flags newly pressed keys for one cycle.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kp    : keypad_scan_if.master (row in; col, key_state, key_pulse out)
//
// state | meaning
// COL0  | col[0] driven low, sampling keys 0,4,8,12
// COL1  | col[1] driven low, sampling keys 1,5,9,13
// COL2  | col[2] driven low, sampling keys 2,6,10,14
// COL3  | col[3] driven low, sampling keys 3,7,11,15; snapshot completes
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);

    scan_state_e         state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [NUM_ROWS-1:0] row_s;
    logic [NUM_ROWS-1:0] raw_col;
    logic [NUM_KEYS-1:0] acc_q, snap_d;
    logic [NUM_KEYS-1:0] prev_q, prev_d;
    logic [STB_W-1:0]    stable_q, stable_d;
    logic                accept_q, accept_d;
    logic [NUM_KEYS-1:0] key_state_q, key_state_d;
    logic [NUM_KEYS-1:0] key_pulse_q, key_pulse_d;
    logic                tc;
    logic                snap_done;
    logic [3:0]          idx;

    keypad_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (kp.row),
        .q_o   (row_s)
    );

    assign tc        = (div_q == DIV_W'(SCAN_DIV - 1));
    assign snap_done = tc && (state_q == COL3);
    assign raw_col   = ~row_s;
    assign div_d     = tc ? '0 : div_q + DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COL0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tc) begin
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                COL2:    state_d = COL3;
                COL3:    state_d = COL0;
                default: state_d = COL0;
            endcase
        end
    end

    // Merge the current column's rows into the partial snapshot; on the COL3
    // slot end snap_d is the complete snapshot.
    always_comb begin
        snap_d = acc_q;
        idx    = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            idx         = 4'(r * NUM_COLS) + {2'b00, state_q};
            snap_d[idx] = raw_col[r];
        end
    end

    always_comb begin
        prev_d      = prev_q;
        stable_d    = stable_q;
        accept_d    = 1'b0;
        key_state_d = key_state_q;
        key_pulse_d = '0;
        if (snap_done) begin
            if (snap_d != prev_q) begin
                prev_d   = snap_d;
                stable_d = '0;
            end else if (stable_q != STB_W'(DEBOUNCE_SCANS)) begin
                stable_d = stable_q + STB_W'(1);
                // Only the step onto the saturation value accepts the pattern.
                accept_d = (stable_q == STB_W'(DEBOUNCE_SCANS - 1));
            end
        end
        if (accept_q) begin
            key_state_d = prev_q;
            key_pulse_d = prev_q & ~key_state_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            accept_q    <= 1'b0;
            key_state_q <= '0;
            key_pulse_q <= '0;
        end else begin
            if (tc) begin
                acc_q <= snap_d;
            end
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            accept_q    <= accept_d;
            key_state_q <= key_state_d;
            key_pulse_q <= key_pulse_d;
        end
    end

    assign kp.col       = col_drive(state_q);
    assign kp.key_state = key_state_q;
    assign kp.key_pulse = key_pulse_q;

endmodule

// File: tb/tb_keypad_scan.sv
module tb_keypad_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  row_m;
    int          n_total;
    int          n_pass;

    keypad_scan_if kif ();

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_m = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!kif.col[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[r*4+c]) row_m[r] = 1'b0;
                end
            end
        end
    end
    assign kif.row = row_m;

    typedef struct {
        logic [15:0] keys;
        int          scans;
        int          exp_cnt;
        int          exp_edge;
        logic [15:0] exp_pval;
        logic [15:0] exp_state;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic run(input int nedges, output int cnt, output int first, output logic [15:0] val);
        cnt   = 0;
        first = -1;
        val   = '0;
        for (int e = 1; e <= nedges; e++) begin
            @(posedge clk);
            #1;
            if (kif.key_pulse != 16'h0000) begin
                cnt++;
                if (first < 0) begin
                    first = e;
                    val   = kif.key_pulse;
                end
            end
        end
    endtask

    int          ce[6];
    logic [3:0]  cv[6];
    int          k;
    int          cnt, first;
    logic [15:0] pval;

    initial begin
        n_total = 0;
        n_pass  = 0;
        //         keys    scans cnt edge pval     state
        vecs[0]  = '{16'h0000, 5, 0, -1, 16'h0000, 16'h0000};
        vecs[1]  = '{16'h0020, 6, 1, 65, 16'h0020, 16'h0020};
        vecs[2]  = '{16'h0020, 4, 0, -1, 16'h0000, 16'h0020};
        vecs[3]  = '{16'h0000, 6, 0, -1, 16'h0000, 16'h0000};
        vecs[4]  = '{16'h0020, 2, 0, -1, 16'h0000, 16'h0000};
        vecs[5]  = '{16'h0000, 2, 0, -1, 16'h0000, 16'h0000};
        vecs[6]  = '{16'h0020, 2, 0, -1, 16'h0000, 16'h0000};
        vecs[7]  = '{16'h0000, 2, 0, -1, 16'h0000, 16'h0000};
        vecs[8]  = '{16'h0020, 2, 0, -1, 16'h0000, 16'h0000};
        vecs[9]  = '{16'h0000, 6, 0, -1, 16'h0000, 16'h0000};
        vecs[10] = '{16'h8001, 6, 1, 65, 16'h8001, 16'h8001};

        ce = '{3, 4, 8, 12, 15, 16};
        cv = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0111, 4'b1110};

        keys  = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_col", 32'(kif.col), 32'(4'b1110));
        check("reset_state", 32'(kif.key_state), 32'h0);
        check("reset_pulse", 32'(kif.key_pulse), 32'h0);
        #3 rst_n = 1'b1;

        // Column stepping during the first scan after release.
        k = 0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            if (k < 6 && e == ce[k]) begin
                check($sformatf("col_edge%0d", e), 32'(kif.col), 32'(cv[k]));
                k++;
            end
        end

        for (int i = 0; i < 11; i++) begin
            keys = vecs[i].keys;
            run(vecs[i].scans * 16, cnt, first, pval);
            check($sformatf("v%0d_pulse_cnt", i), 32'(cnt), 32'(vecs[i].exp_cnt));
            check($sformatf("v%0d_pulse_edge", i), 32'(first), 32'(vecs[i].exp_edge));
            check($sformatf("v%0d_pulse_val", i), 32'(pval), 32'(vecs[i].exp_pval));
            check($sformatf("v%0d_key_state", i), 32'(kif.key_state), 32'(vecs[i].exp_state));
        end

        // Reset during scan 2 of a key-5 debounce, key held through reset.
        keys = 16'h0020;
        run(24, cnt, first, pval);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_col", 32'(kif.col), 32'(4'b1110));
        check("midrst_state", 32'(kif.key_state), 32'h0);
        check("midrst_pulse", 32'(kif.key_pulse), 32'h0);
        repeat (2) @(posedge clk);
        #4 rst_n = 1'b1;
        run(96, cnt, first, pval);
        check("postrst_pulse_cnt", 32'(cnt), 32'd1);
        check("postrst_pulse_edge", 32'(first), 32'd65);
        check("postrst_pulse_val", 32'(pval), 32'h0020);
        check("postrst_key_state", 32'(kif.key_state), 32'h0020);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
